time_base_counter: RTL and testbench

- Free-running time-of-day counter for the alarm clock.
- Divides the system clock into a 1 s tick and keeps seconds, minutes and hours as binary values (0-59, 0-59, 0-23).
- Sits directly upstream of the tens/ones digit splitters; each 7-bit output feeds one splitter's NUMBER input.
- Also provides a user set mode for adjusting the time from push-buttons.

---
 rtl/time_base_counter.sv | 161 ++++++++++++++++
 tb/tb_time_base_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/time_base_counter.sv
// time_base_counter: free-running time-of-day counter for the alarm clock.
//
// Divides CLK into a 1 s TICK and keeps SEC/MIN/HOUR as binary values
// (0-59, 0-59, 0-23). While SET_MODE is high the time is frozen and
// each rising edge of SET_INC bumps the field chosen by SET_SEL. Each
// bump wraps within its own field and never carries into another field.
//
// Optional feature macro: ALARM_MATCH_EN
//   When defined, ALARM goes high for one second when a tick lands on
//   ALARM_HOUR:ALARM_MIN:00. When not defined, ALARM is tied to 0 and
//   the alarm inputs are ignored.
//
// Ports:
//   CLK         system clock
//   RESET       synchronous reset, active-high, overrides all inputs
//   SET_MODE    level; 1 = time frozen and editable
//   SET_SEL     field to edit: 0 sec, 1 min, 2 hour, 3 none
//   SET_INC     debounced button; its rising edge increments the field
//   TICK        one-cycle pulse per second (run mode only)
//   SEC/MIN     0-59, binary
//   HOUR        0-23, binary
//   ALARM_HOUR  alarm hour (feature only)
//   ALARM_MIN   alarm minute (feature only)
//   ALARM       alarm indication
module time_base_counter #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SET_MODE,
  input  logic [1:0] SET_SEL,
  input  logic       SET_INC,
  output logic       TICK,
  output logic [6:0] SEC,
  output logic [6:0] MIN,
  output logic [6:0] HOUR,
  input  logic [6:0] ALARM_HOUR,
  input  logic [6:0] ALARM_MIN,
  output logic       ALARM
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [0:0] {StRun, StSet} mode_e;

  mode_e           mode;
  logic [PreW-1:0] pre_q, pre_d;
  logic            tick_q, tick_d;
  logic [6:0]      sec_q, sec_d;
  logic [6:0]      min_q, min_d;
  logic [6:0]      hour_q, hour_d;
  logic            inc_q;
  logic            inc_rise;
  logic            tick_fire;
  logic            sec_wrap, min_wrap, hour_wrap;

  always_comb begin
    // The mode follows SET_MODE directly, with no extra latency.
    mode      = SET_MODE ? StSet : StRun;
    pre_d     = pre_q;
    tick_d    = 1'b0;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    tick_fire = 1'b0;
    inc_rise  = SET_INC & ~inc_q;
    sec_wrap  = (sec_q == 7'd59);
    min_wrap  = (min_q == 7'd59);
    hour_wrap = (hour_q == 7'd23);

    unique case (mode)
      StRun: begin
        if (pre_q == PreMax) begin
          pre_d     = '0;
          tick_d    = 1'b1;
          tick_fire = 1'b1;
          sec_d     = sec_wrap ? 7'd0 : sec_q + 7'd1;
          if (sec_wrap) begin
            min_d = min_wrap ? 7'd0 : min_q + 7'd1;
            if (min_wrap) begin
              hour_d = hour_wrap ? 7'd0 : hour_q + 7'd1;
            end
          end
        end else begin
          pre_d = pre_q + PreW'(1);
        end
      end
      StSet: begin
        // Prescaler held at 0, so the first tick after leaving set mode
        // comes a full TICK_DIV cycles later.
        pre_d = '0;
        if (inc_rise) begin
          unique case (SET_SEL)
            2'd0:    sec_d  = sec_wrap  ? 7'd0 : sec_q + 7'd1;
            2'd1:    min_d  = min_wrap  ? 7'd0 : min_q + 7'd1;
            2'd2:    hour_d = hour_wrap ? 7'd0 : hour_q + 7'd1;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      sec_q  <= 7'd0;
      min_q  <= 7'd0;
      hour_q <= 7'd0;
      inc_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      inc_q  <= SET_INC;
    end
  end

`ifdef ALARM_MATCH_EN
  logic alarm_q, alarm_d;
  logic alarm_hit;

  always_comb begin
    // Out-of-range alarm settings are rejected explicitly so they never match.
    alarm_hit = (ALARM_HOUR < 7'd24) && (ALARM_MIN < 7'd60) &&
                (hour_d == ALARM_HOUR) && (min_d == ALARM_MIN) && (sec_d == 7'd0);
    alarm_d   = alarm_q;
    if (mode == StSet) begin
      alarm_d = 1'b0;
    end else if (tick_fire) begin
      // Re-evaluated on every tick, so a hit lasts exactly one second.
      alarm_d = alarm_hit;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign ALARM = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{ALARM_HOUR, ALARM_MIN, tick_fire};
  assign ALARM        = 1'b0;
`endif

  assign TICK = tick_q;
  assign SEC  = sec_q;
  assign MIN  = min_q;
  assign HOUR = hour_q;

endmodule

// File: tb/tb_time_base_counter.sv
// Directed self-checking bench for time_base_counter with TICK_DIV = 4.
module tb_time_base_counter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SET_MODE;
  logic [1:0] SET_SEL;
  logic       SET_INC;
  logic       TICK;
  logic [6:0] SEC, MIN, HOUR;
  logic [6:0] ALARM_HOUR, ALARM_MIN;
  logic       ALARM;

  int compared = 0;
  int failed   = 0;

`ifdef ALARM_MATCH_EN
  localparam logic AlarmOn = 1'b1;
`else
  localparam logic AlarmOn = 1'b0;
`endif

  time_base_counter #(.TICK_DIV(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SET_MODE   (SET_MODE),
    .SET_SEL    (SET_SEL),
    .SET_INC    (SET_INC),
    .TICK       (TICK),
    .SEC        (SEC),
    .MIN        (MIN),
    .HOUR       (HOUR),
    .ALARM_HOUR (ALARM_HOUR),
    .ALARM_MIN  (ALARM_MIN),
    .ALARM      (ALARM)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, " hour"}, 32'(HOUR), 32'(h));
    check({tag, " min"},  32'(MIN),  32'(m));
    check({tag, " sec"},  32'(SEC),  32'(s));
  endtask

  task automatic pulse_inc(input logic [1:0] sel);
    SET_SEL = sel;
    SET_INC = 1'b1;
    step(1);
    SET_INC = 1'b0;
    step(1);
  endtask

  // Reset into set mode and dial in h:m:s from 00:00:00.
  task automatic set_time(input int h, input int m, input int s);
    RESET    = 1'b1;
    SET_MODE = 1'b1;
    SET_INC  = 1'b0;
    step(1);
    RESET = 1'b0;
    for (int i = 0; i < s; i++) pulse_inc(2'd0);
    for (int i = 0; i < m; i++) pulse_inc(2'd1);
    for (int i = 0; i < h; i++) pulse_inc(2'd2);
  endtask

  initial begin
    RESET      = 1'b1;
    SET_MODE   = 1'b0;
    SET_SEL    = 2'd3;
    SET_INC    = 1'b0;
    ALARM_HOUR = 7'd99;  // out of range: must never match
    ALARM_MIN  = 7'd0;
    step(2);
    check("reset tick", 32'(TICK), 0);
    check_time("reset", 0, 0, 0);
    check("reset alarm", 32'(ALARM), 0);

    // Free run: ticks on edges 4, 8, 12 after release.
    RESET = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      check($sformatf("run tick c%0d", c), 32'(TICK), 32'((c % 4) == 0));
      check($sformatf("run sec c%0d", c), 32'(SEC), 32'(c / 4));
    end
    check_time("run 12", 0, 0, 3);
    check("run alarm out-of-range", 32'(ALARM), 0);

    // 00:59:59 + tick -> 01:00:00
    set_time(0, 59, 59);
    check_time("set 005959", 0, 59, 59);
    SET_MODE = 1'b0;
    step(3);
    check("restart no tick", 32'(TICK), 0);
    check_time("restart held", 0, 59, 59);
    step(1);
    check("carry tick", 32'(TICK), 1);
    check_time("carry hour", 1, 0, 0);

    // 23:59:59 + tick -> 00:00:00
    set_time(23, 59, 59);
    check_time("set 235959", 23, 59, 59);
    SET_MODE = 1'b0;
    step(4);
    check("midnight tick", 32'(TICK), 1);
    check_time("midnight", 0, 0, 0);

    // Set-mode field wrap without carry; held button counts once.
    set_time(5, 59, 0);
    pulse_inc(2'd1);
    check_time("min wrap no carry", 5, 0, 0);
    SET_SEL = 2'd0;
    SET_INC = 1'b1;
    step(10);
    SET_INC = 1'b0;
    step(1);
    check_time("held inc once", 5, 0, 1);
    pulse_inc(2'd3);
    check_time("sel none", 5, 0, 1);
    pulse_inc(2'd2);
    check_time("hour inc", 6, 0, 1);
    check("set mode tick", 32'(TICK), 0);

    // Entering set mode on the prescaler wrap cycle suppresses the tick.
    RESET    = 1'b1;
    SET_MODE = 1'b0;
    step(1);
    RESET = 1'b0;
    step(3);
    SET_MODE = 1'b1;
    step(1);
    check("wrap set tick", 32'(TICK), 0);
    check("wrap set sec", 32'(SEC), 0);
    SET_MODE = 1'b0;
    step(3);
    check("release early tick", 32'(TICK), 0);
    step(1);
    check("release tick", 32'(TICK), 1);
    check("release sec", 32'(SEC), 1);

    // Reset mid-run at 12:34:56 together with an SET_INC edge.
    set_time(12, 34, 56);
    SET_MODE = 1'b0;
    step(2);
    check_time("pre-reset", 12, 34, 56);
    RESET   = 1'b1;
    SET_SEL = 2'd0;
    SET_INC = 1'b1;
    step(1);
    check("reset mid tick", 32'(TICK), 0);
    check_time("reset mid", 0, 0, 0);
    check("reset mid alarm", 32'(ALARM), 0);
    RESET   = 1'b0;
    SET_INC = 1'b0;

    // Alarm at 07:30:00: high for exactly one second.
    ALARM_HOUR = 7'd7;
    ALARM_MIN  = 7'd30;
    set_time(7, 29, 59);
    SET_MODE = 1'b0;
    step(3);
    check("alarm before", 32'(ALARM), 0);
    step(1);
    check("alarm tick", 32'(TICK), 1);
    check_time("alarm time", 7, 30, 0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("alarm on c%0d", c), 32'(ALARM), 32'(AlarmOn));
      step(1);
    end
    check("alarm next tick", 32'(TICK), 1);
    check("alarm cleared", 32'(ALARM), 0);
    check("alarm next sec", 32'(SEC), 1);

    // Entering set mode clears the alarm immediately.
    set_time(7, 29, 59);
    SET_MODE = 1'b0;
    step(4);
    check("alarm again", 32'(ALARM), 32'(AlarmOn));
    SET_MODE = 1'b1;
    step(1);
    check("alarm set clear", 32'(ALARM), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
